// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encoding and WIDTH legality limits for the serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
  function automatic bit width_ok(int w);
    return w >= WIDTH_MIN && w <= WIDTH_MAX;
  endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle between the operand source and the serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic start, c_in, sub, busy, done, c_out, ovf;
  logic [WIDTH-1:0] a_in, b_in, sum;
  modport master(output start, a_in, b_in, c_in, sub, input busy, done, sum, c_out, ovf);
  modport slave(input start, a_in, b_in, c_in, sub, output busy, done, sum, c_out, ovf);
endinterface

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational 1-bit full adder
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder/subtractor with registered carry and done pulse
module serial_adder import serial_adder_pkg::*; #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_adder_if.slave io
);
  localparam int CW = $clog2(WIDTH);
  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cy_q, cy_d, co_q, co_d, ovf_q, ovf_d, s, co;
  fa_cell u_fa (.a_i(a_q[0]), .b_i(b_q[0]), .ci_i(cy_q), .s_o(s), .co_o(co));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: if (io.start) begin
        a_d     = io.a_in;
        b_d     = io.sub ? ~io.b_in : io.b_in;
        cy_d    = io.sub ^ io.c_in;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = WIDTH'({s, res_q} >> 1);
        cy_d  = co;
        cnt_d = cnt_q + CW'(1);
        // cy_q here is the carry entering the MSB, so ovf compares it with the carry leaving it
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = res_d;
          co_d    = co;
          ovf_d   = cy_q ^ co;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  assign io.busy  = state_q == ST_RUN;
  assign io.done  = state_q == ST_DONE;
  assign io.sum   = sum_q;
  assign io.c_out = co_q;
  assign io.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for the serial adder at WIDTH 8, 2 and 32
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_adder_if #(8)  io8 ();
  serial_adder_if #(2)  io2 ();
  serial_adder_if #(32) io32 ();
  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .io(io8));
  serial_adder #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .io(io2));
  serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .io(io32));
  typedef struct {logic [7:0] sum; logic co; logic ov;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, dones = 0;
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  exp_t e;
  always @(negedge clk) if (io8.done) begin
    dones++;
    if (sb.size() == 0) check("spurious_done", 1, 0);
    else begin
      e = sb.pop_front();
      check("sum", io8.sum, e.sum);
      check("c_out", io8.c_out, e.co);
      check("ovf", io8.ovf, e.ov);
    end
  end
  task automatic op(logic [7:0] a, logic [7:0] b, logic ci, logic sub, bit poke);
    logic [7:0] bb;
    logic [8:0] full;
    exp_t x;
    int lat = 0, bc = 0;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 9'(sub ? !ci : ci);
    x.sum = full[7:0];
    x.co  = full[8];
    x.ov  = (a[7] == bb[7]) && (full[7] != a[7]);
    @(negedge clk);
    io8.a_in = a; io8.b_in = b; io8.c_in = ci; io8.sub = sub; io8.start = 1'b1;
    sb.push_back(x);
    @(posedge clk); #1;
    io8.start = 1'b0;
    bc += int'(io8.busy);
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (io8.done) lat = i;
      else bc += int'(io8.busy);
      if (poke && (i == 3 || i == 8)) begin
        io8.start = 1'b1; io8.a_in = ~a; io8.b_in = 8'h11; io8.sub = ~sub;
      end else io8.start = 1'b0;
    end
    check("latency", lat, 8);
    check("busy_cycles", bc, 8);
    @(posedge clk); #1;
    io8.start = 1'b0;
    check("done_one_cycle", io8.done, 0);
    @(posedge clk); #1;
    check("idle_after", io8.busy, 0);
    check("sum_hold", io8.sum, x.sum);
  endtask
  initial begin
    int d0, lat2, lat32;
    {io8.start, io8.a_in, io8.b_in, io8.c_in, io8.sub} = '0;
    {io2.start, io2.a_in, io2.b_in, io2.c_in, io2.sub} = '0;
    {io32.start, io32.a_in, io32.b_in, io32.c_in, io32.sub} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", io8.busy, 0);
    check("rst_done", io8.done, 0);
    check("rst_sum", io8.sum, 0);
    check("rst_c_out", io8.c_out, 0);
    check("rst_ovf", io8.ovf, 0);
    @(negedge clk) rst = 1'b0;
    op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
    op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    op(8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
    op(8'h12, 8'h34, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++)
      op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    op(8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
    d0 = dones;
    @(negedge clk);
    io8.a_in = 8'h5A; io8.b_in = 8'h33; io8.c_in = 1'b0; io8.sub = 1'b0; io8.start = 1'b1;
    @(posedge clk); #1;
    io8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", io8.busy, 0);
    check("abort_sum", io8.sum, 0);
    check("abort_done", io8.done, 0);
    check("abort_c_out", io8.c_out, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", dones, d0);
    op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    io2.a_in = 2'h3; io2.b_in = 2'h1; io2.start = 1'b1;
    io32.a_in = 32'hFFFF_FFFF; io32.b_in = 32'h1; io32.start = 1'b1;
    @(posedge clk); #1;
    io2.start = 1'b0; io32.start = 1'b0;
    lat2 = 0; lat32 = 0;
    for (int i = 1; i <= 40 && lat32 == 0; i++) begin
      @(posedge clk); #1;
      if (io2.done && lat2 == 0) begin
        lat2 = i;
        check("w2_sum", io2.sum, 0);
        check("w2_c_out", io2.c_out, 1);
      end
      if (io32.done) begin
        lat32 = i;
        check("w32_sum", io32.sum, 0);
        check("w32_c_out", io32.c_out, 1);
      end
    end
    check("w2_latency", lat2, 2);
    check("w32_latency", lat32, 32);
    check("done_total", dones, 13);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
